regfile_dual_read_arb: RTL

Eight-entry × 16-bit register file with one write port and two independent read ports, which share a single physical read path through a round-robin arbiter. It is the read-side counterpart to the team's dual-write/single-read register block. Two consumers (e.g. two datapath stages) issue strobed read requests and receive tagged, registered responses while a single producer writes.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_dual_read_arb_rr_arb2.sv | 54 +++++
 rtl/regfile_dual_read_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file family: geometry of the storage
// array and the port identifier used by the round-robin arbiters for the
// priority state and for indexing the grant vector.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  // Port identifier; also the bit index of that port in req/gnt vectors.
  typedef enum logic {
    PORT_1 = 1'b0,
    PORT_2 = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_dual_read_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a single priority flop.
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high; priority returns to PORT_1
//   i_req    in   [1:0] request vector, bit index = port_e
//   o_gnt    out  [1:0] one-hot grant (or zero), combinational from i_req
//   o_prio   out  current priority state (debug visibility of the FSM)
// The favoured port wins only when both request; a lone requester always
// wins. After any grant the priority points at the port that was not
// granted; a cycle without a grant leaves it unchanged.
// -----------------------------------------------------------------------------
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output port_e      o_prio
);

  port_e      r_prio;
  port_e      w_prio_nxt;
  logic [1:0] w_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= PORT_1;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  always_comb begin
    w_gnt      = 2'b00;
    w_prio_nxt = r_prio;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = (r_prio == PORT_1) ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
    if (w_gnt[0]) begin
      w_prio_nxt = PORT_2;
    end else if (w_gnt[1]) begin
      w_prio_nxt = PORT_1;
    end
  end

  assign o_gnt  = w_gnt;
  assign o_prio = r_prio;

endmodule

// File: rtl/regfile_dual_read_arb.sv
// -----------------------------------------------------------------------------
// regfile_dual_read_arb
// DEPTH x DATA_W register file, one write port, two read ports sharing one
// physical read path through a round-robin arbiter.
//   clk                      in   clock, rising edge
//   reset                    in   asynchronous, active-high; clears everything
//   i_wr_en/i_wr_addr/i_wr_data  in   write port, never stalled
//   i_rd_req_k / i_rd_addr_k in   read strobe and address, port k = 1,2
//   o_rd_busy_k              out  request pending on port k
//   o_rd_valid_k             out  one-cycle pulse, o_rd_data_k is fresh
//   o_rd_data_k              out  registered read data, held between pulses
//   o_dbg_prio               out  arbiter priority state (0 favours port 1)
//
// Read handshake: a strobe on i_rd_req_k is accepted at an edge only when
// o_rd_busy_k is low at that edge; otherwise it is dropped with no response.
// Every accepted request produces exactly one o_rd_valid_k pulse, unless a
// reset intervenes, which discards it. Data is captured from the array as it
// was before the grant edge's write (read-old on a same-address collision).
// -----------------------------------------------------------------------------
module regfile_dual_read_arb #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int DEPTH  = regfile_pkg::DEPTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req_1,
  input  logic [ADDR_W-1:0] i_rd_addr_1,
  input  logic              i_rd_req_2,
  input  logic [ADDR_W-1:0] i_rd_addr_2,
  output logic              o_rd_busy_1,
  output logic              o_rd_busy_2,
  output logic              o_rd_valid_1,
  output logic              o_rd_valid_2,
  output logic [DATA_W-1:0] o_rd_data_1,
  output logic [DATA_W-1:0] o_rd_data_2,
  output logic              o_dbg_prio
);

  import regfile_pkg::*;

  // Every address must map to an entry, so out-of-range reads cannot occur.
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_geometry
    $error("regfile_dual_read_arb: DEPTH must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_pend_1;
  logic              r_pend_2;
  logic [ADDR_W-1:0] r_addr_1;
  logic [ADDR_W-1:0] r_addr_2;
  logic              r_rd_valid_1;
  logic              r_rd_valid_2;
  logic [DATA_W-1:0] r_rd_data_1;
  logic [DATA_W-1:0] r_rd_data_2;

  logic [1:0]        w_gnt;
  port_e             w_prio;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  ({r_pend_2, r_pend_1}),
    .o_gnt  (w_gnt),
    .o_prio (w_prio)
  );

  // Storage. Reads below sample r_mem before this edge's update, which gives
  // read-old behaviour on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Port 1 request capture and response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_1     <= 1'b0;
      r_addr_1     <= '0;
      r_rd_valid_1 <= 1'b0;
      r_rd_data_1  <= '0;
    end else begin
      r_rd_valid_1 <= w_gnt[0];
      if (w_gnt[0]) begin
        r_rd_data_1 <= r_mem[r_addr_1];
        r_pend_1    <= 1'b0;
      end else if (i_rd_req_1 && !r_pend_1) begin
        r_pend_1 <= 1'b1;
        r_addr_1 <= i_rd_addr_1;
      end
    end
  end

  // Port 2 request capture and response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_2     <= 1'b0;
      r_addr_2     <= '0;
      r_rd_valid_2 <= 1'b0;
      r_rd_data_2  <= '0;
    end else begin
      r_rd_valid_2 <= w_gnt[1];
      if (w_gnt[1]) begin
        r_rd_data_2 <= r_mem[r_addr_2];
        r_pend_2    <= 1'b0;
      end else if (i_rd_req_2 && !r_pend_2) begin
        r_pend_2 <= 1'b1;
        r_addr_2 <= i_rd_addr_2;
      end
    end
  end

  assign o_rd_busy_1  = r_pend_1;
  assign o_rd_busy_2  = r_pend_2;
  assign o_rd_valid_1 = r_rd_valid_1;
  assign o_rd_valid_2 = r_rd_valid_2;
  assign o_rd_data_1  = r_rd_data_1;
  assign o_rd_data_2  = r_rd_data_2;
  assign o_dbg_prio   = w_prio;

endmodule
